// File: rtl/systolic_ctrl_pkg.sv
// Shared types and default geometry for the systolic array sequencer.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    WAIT,
    EMIT
  } state_e;

  localparam int DEF_ROWS = 3;
  localparam int DEF_COLS = 4;
  localparam int DEF_K_W  = 8;
  localparam int DEF_TMO  = 255;

  // Skew pipeline depth: last operand needs ROWS+COLS-2 extra hops to reach the far corner.
  function automatic int drain_cycles(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

  localparam int DRAIN_CYCLES = drain_cycles(DEF_ROWS, DEF_COLS);
  localparam int NUM_MAC      = DEF_ROWS * DEF_COLS;

endpackage

// File: rtl/systolic_ctrl_done_tracker.sv
// Sticky per-MAC done mask; all_done also looks at this cycle's flags so a
// late bit is honoured without an extra cycle of latency.
module done_tracker #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_cap,
  input  logic [N-1:0] i_mac_done,
  output logic         o_all_done
);

  logic [N-1:0] r_mask;

  // Accumulate done flags while a job is in its compute phases.
  always_ff @(posedge clk) begin
    if (reset || i_clr) r_mask <= '0;
    else if (i_cap)     r_mask <= r_mask | i_mac_done;
  end

  assign o_all_done = &(r_mask | i_mac_done);

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the systolic MAC array: clear, feed K beats, drain the
// skew, wait on every MAC unit (with timeout), then stream result rows.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int K_W  = DEF_K_W,
  parameter int TMO  = DEF_TMO
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [K_W-1:0]                      k_len,
  output logic                                busy,
  output logic                                mac_clr,
  output logic                                feed_valid,
  output logic [K_W-1:0]                      feed_idx,
  input  logic [ROWS*COLS-1:0]                mac_done,
  output logic                                en_y,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] out_row,
  output logic                                job_done,
  output logic                                err
);

  // Requires ROWS+COLS > 2 so the drain phase is at least one cycle.
  localparam int L_DRAIN = drain_cycles(ROWS, COLS);
  localparam int L_NMAC  = ROWS * COLS;
  localparam int L_DR_W  = (L_DRAIN > 1) ? $clog2(L_DRAIN) : 1;
  localparam int L_TMO_W = $clog2(TMO + 1);
  localparam int L_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e               r_state, w_next;
  logic [K_W-1:0]       r_k;
  logic [K_W-1:0]       r_cnt;
  logic [L_DR_W-1:0]    r_drain;
  logic [L_TMO_W-1:0]   r_tmo;
  logic [L_ROW_W-1:0]   r_row;
  logic                 r_err, r_job_done;

  logic w_all_done, w_accept, w_feed_last, w_drain_last, w_tmo_hit, w_row_last;
  logic w_start_ok, w_start_bad, w_clr, w_cap;

  assign w_start_ok   = (r_state == IDLE) && start && (k_len != '0);
  assign w_start_bad  = (r_state == IDLE) && start && (k_len == '0);
  assign w_feed_last  = (r_cnt == r_k - K_W'(1));
  assign w_drain_last = (r_drain == L_DR_W'(L_DRAIN - 1));
  assign w_tmo_hit    = (r_tmo == L_TMO_W'(TMO - 1));
  assign w_row_last   = (r_row == L_ROW_W'(ROWS - 1));
  assign w_accept     = (r_state == EMIT) && out_ready;
  assign w_clr        = (r_state == CLEAR);
  assign w_cap        = (r_state == FEED) || (r_state == DRAIN) || (r_state == WAIT);

  done_tracker #(.N(L_NMAC)) u_done (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_cap      (w_cap),
    .i_mac_done (mac_done),
    .o_all_done (w_all_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_start_ok) w_next = CLEAR;
      CLEAR: w_next = FEED;
      FEED:  if (w_feed_last) w_next = DRAIN;
      DRAIN: if (w_drain_last) w_next = WAIT;
      WAIT:  if (w_all_done) w_next = EMIT;
             else if (w_tmo_hit) w_next = IDLE;
      EMIT:  if (w_accept && w_row_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Phase counters and registered event pulses; counters idle at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k        <= '0;
      r_cnt      <= '0;
      r_drain    <= '0;
      r_tmo      <= '0;
      r_row      <= '0;
      r_err      <= 1'b0;
      r_job_done <= 1'b0;
    end else begin
      r_err      <= w_start_bad || ((r_state == WAIT) && !w_all_done && w_tmo_hit);
      r_job_done <= w_accept && w_row_last;
      if (w_start_ok) r_k <= k_len;
      r_cnt   <= ((r_state == FEED) && !w_feed_last) ? r_cnt + K_W'(1) : '0;
      r_drain <= ((r_state == DRAIN) && !w_drain_last) ? r_drain + L_DR_W'(1) : '0;
      r_tmo   <= (r_state == WAIT) ? r_tmo + L_TMO_W'(1) : '0;
      if (r_state != EMIT)  r_row <= '0;
      else if (w_accept)    r_row <= w_row_last ? '0 : r_row + L_ROW_W'(1);
    end
  end

  assign busy       = (r_state != IDLE);
  assign mac_clr    = (r_state == CLEAR);
  assign feed_valid = (r_state == FEED);
  assign feed_idx   = (r_state == FEED) ? r_cnt : '0;
  assign en_y       = (r_state == EMIT);
  assign out_valid  = (r_state == EMIT);
  assign out_row    = (r_state == EMIT) ? r_row : '0;
  assign job_done   = r_job_done;
  assign err        = r_err;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl at default geometry (3x4, K_W=8, TMO=255).
module tb_systolic_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  k_len;
  logic        busy, mac_clr, feed_valid;
  logic [7:0]  feed_idx;
  logic [11:0] mac_done;
  logic        en_y, out_valid, out_ready;
  logic [1:0]  out_row;
  logic        job_done, err;

  int n_assert = 0;
  int n_fail   = 0;
  int clr_cnt  = 0;
  int en_cnt   = 0;

  systolic_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .mac_clr    (mac_clr),
    .feed_valid (feed_valid),
    .feed_idx   (feed_idx),
    .mac_done   (mac_done),
    .en_y       (en_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .job_done   (job_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mac_clr) clr_cnt++;
    if (en_y)    en_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic start_job(input logic [7:0] k);
    start = 1'b1;
    k_len = k;
    tick();
    start = 1'b0;
    k_len = '0;
  endtask

  function automatic logic [31:0] all_outs();
    return {17'd0, busy, mac_clr, feed_valid, feed_idx, en_y, out_valid, out_row, job_done, err};
  endfunction

  initial begin
    int base, bad;
    reset = 1'b1; start = 1'b0; k_len = '0; mac_done = '0; out_ready = 1'b1;
    tick();
    chk("reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_outs", all_outs(), 32'd0);

    // Basic job, k=4, all done bits pulse once in DRAIN.
    base = clr_cnt;
    start_job(8'd4);                                    // T+1
    chk("basic_clear", {busy, mac_clr, feed_valid}, 3'b110);
    tick();                                             // T+2
    for (int i = 0; i < 4; i++) begin
      chk("basic_feed", {feed_valid, feed_idx}, {1'b1, 8'(i)});
      tick();
    end                                                 // T+6 DRAIN
    bad = 0;
    for (int d = 0; d < 5; d++) begin
      if (feed_valid || en_y || !busy) bad++;
      mac_done = (d == 0) ? 12'hFFF : 12'h000;
      tick();
    end
    mac_done = '0;
    chk("basic_drain", 32'(bad), 32'd0);
    chk("basic_wait", {busy, en_y, feed_valid}, 3'b100); // T+11
    base = base;
    tick();                                             // T+12 EMIT
    for (int r = 0; r < 3; r++) begin
      chk("basic_emit", {en_y, out_valid, out_row, job_done}, {1'b1, 1'b1, 2'(r), 1'b0});
      tick();
    end                                                 // T+15
    chk("basic_job_done", {job_done, busy}, 2'b10);
    chk("basic_clr_once", 32'(clr_cnt - base), 32'd1);
    tick();
    chk("basic_done_pulse", {job_done, err}, 2'b00);

    // Backpressure, k=2, done held as a level.
    mac_done = 12'hFFF;
    start_job(8'd2);                                    // T+1
    repeat (9) tick();                                  // T+10 EMIT row 0
    chk("bp_row0", {out_valid, out_row}, {1'b1, 2'd0});
    tick();                                             // T+11
    chk("bp_row1", {out_valid, out_row}, {1'b1, 2'd1});
    out_ready = 1'b0;
    tick();                                             // T+12
    chk("bp_hold_a", {out_valid, out_row, job_done}, {1'b1, 2'd1, 1'b0});
    tick();                                             // T+13
    chk("bp_hold_b", {out_valid, out_row, job_done}, {1'b1, 2'd1, 1'b0});
    out_ready = 1'b1;
    tick();                                             // T+14
    chk("bp_row2", {out_valid, out_row, job_done}, {1'b1, 2'd2, 1'b0});
    tick();                                             // T+15
    chk("bp_job_done", {job_done, busy}, 2'b10);
    mac_done = '0;
    tick();

    // Staggered done bits in WAIT, bit 11 arrives last on WAIT cycle 12.
    start_job(8'd1);                                    // T+1
    repeat (7) tick();                                  // T+8 WAIT
    bad = 0;
    for (int w = 0; w < 13; w++) begin
      if (en_y || !busy) bad++;
      mac_done = (w < 11) ? 12'(1 << w) : (w == 12) ? 12'h800 : 12'h000;
      tick();
    end
    mac_done = '0;
    chk("stag_wait", 32'(bad), 32'd0);
    chk("stag_emit", {en_y, out_row}, {1'b1, 2'd0});
    repeat (3) tick();
    chk("stag_job_done", {job_done, busy}, 2'b10);
    tick();

    // Zero-length start is rejected.
    start_job(8'd0);
    chk("zero_err", {err, busy}, 2'b10);
    tick();
    chk("zero_after", {err, busy}, 2'b00);

    // Start during FEED is ignored.
    mac_done = 12'hFFF;
    start_job(8'd3);                                    // T+1
    tick();                                             // T+2 idx 0
    start = 1'b1; k_len = 8'd0;
    tick();                                             // T+3
    chk("busy_start_idx1", {feed_valid, feed_idx, err}, {1'b1, 8'd1, 1'b0});
    start = 1'b0;
    tick();                                             // T+4
    chk("busy_start_idx2", {feed_valid, feed_idx, err}, {1'b1, 8'd2, 1'b0});
    tick();                                             // T+5 DRAIN
    chk("busy_start_drain", {feed_valid, err, busy}, 3'b001);
    repeat (9) tick();                                  // T+14
    chk("busy_start_done", {job_done, err}, 2'b10);
    tick();

    // Timeout: bit 7 never completes.
    mac_done = 12'hF7F;
    base = en_cnt;
    start_job(8'd1);                                    // T+1
    repeat (7) tick();                                  // T+8 WAIT
    bad = 0;
    for (int w = 0; w < 255; w++) begin
      if (err || en_y || !busy) bad++;
      tick();
    end
    chk("tmo_wait", 32'(bad), 32'd0);
    chk("tmo_err", {err, busy, en_y}, 3'b100);
    chk("tmo_no_emit", 32'(en_cnt - base), 32'd0);
    tick();
    chk("tmo_err_pulse", {err, busy}, 2'b00);

    // Reset mid-FEED, then a normal k=1 job.
    mac_done = 12'hFFF;
    start_job(8'd8);                                    // CLEAR
    repeat (4) tick();
    chk("rst_at_idx3", {feed_valid, feed_idx}, {1'b1, 8'd3});
    reset = 1'b1;
    tick();
    chk("rst_mid_outs", all_outs(), 32'd0);
    reset = 1'b0;
    start_job(8'd1);                                    // T+1
    chk("post_rst_clear", {busy, mac_clr}, 2'b11);
    tick();                                             // T+2
    chk("post_rst_feed", {feed_valid, feed_idx}, {1'b1, 8'd0});
    repeat (10) tick();                                 // T+12
    chk("post_rst_done", {job_done, busy, err}, 3'b100);
    mac_done = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
